// File: rtl/exec_sched_pkg.sv
// exec_sched_pkg: shared types and constants for the execute-stage scheduler.
package exec_sched_pkg;

    localparam int OP_W_MDU    = 3;
    localparam int OP_W_FPU    = 5;
    localparam int TIMEOUT_DEF = 64;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_MDU_BUSY = 2'd1,
        ST_FPU_BUSY = 2'd2,
        ST_WB       = 2'd3
    } state_t;

    // Instruction fields held while a multi-cycle unit is working.
    typedef struct packed {
        logic                reg_write;
        logic [4:0]          rd;
        logic [OP_W_FPU-1:0] op;
    } inst_t;

endpackage

// File: rtl/exec_watchdog.sv
// exec_watchdog: 8-bit busy-cycle counter shared by the MDU and FPU busy states.
// The count is 0 in the first busy cycle. expired is raised in the cycle whose
// increment brings the count to limit-1, so a registered abort driven from it
// lands exactly `limit` cycles after the instruction was accepted.
module exec_watchdog (
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       enable,
    input  logic [7:0] limit,
    output logic       expired
);

    logic [7:0] count;

    // Counter: clear wins over increment.
    always_ff @(posedge clk) begin
        if (rst || clear)
            count <= 8'd0;
        else if (enable)
            count <= count + 8'd1;
    end

    assign expired = enable && (count == (limit - 8'd2));

endmodule

// File: rtl/exec_scheduler.sv
// exec_scheduler: sequences the execute stage between the ALU, MDU and FPU and
// owns the shared writeback port.
// Build option: define EXEC_SCHED_FPU_EN to include the FPU path; without it the
// FPU handshake outputs are tied low and fpu_en instructions are reported illegal.
module exec_scheduler
    import exec_sched_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    output logic                issue_ready,
    input  logic                issue_mul_en,
    input  logic                issue_fpu_en,
    input  logic                issue_reg_write,
    input  logic [4:0]          issue_rd,
    input  logic [OP_W_FPU-1:0] issue_op,
    input  logic [31:0]         alu_result,
    input  logic                flush,
    output logic                mdu_start,
    output logic [OP_W_MDU-1:0] mdu_op,
    output logic                mdu_abort,
    input  logic                mdu_done,
    input  logic [31:0]         mdu_result,
    output logic                fpu_start,
    output logic [OP_W_FPU-1:0] fpu_op,
    output logic                fpu_abort,
    input  logic                fpu_done,
    input  logic [31:0]         fpu_result,
    output logic                stall,
    output logic                wb_valid,
    output logic [4:0]          wb_rd,
    output logic [31:0]         wb_data,
    output logic                wb_fp,
    output logic                illegal,
    output logic                timeout
);

    state_t state_q, state_d;
    inst_t  inst_q;
    logic   accept, busy, wd_expired;

    // Next values of the registered outputs.
    logic        mdu_start_d, mdu_abort_d, illegal_d, timeout_d;
    logic        wb_valid_d, wb_fp_d;
    logic [4:0]  wb_rd_d;
    logic [31:0] wb_data_d;
    logic        mdu_start_q, mdu_abort_q, illegal_q, timeout_q;
    logic        wb_valid_q, wb_fp_q;
    logic [4:0]  wb_rd_q;
    logic [31:0] wb_data_q;
`ifdef EXEC_SCHED_FPU_EN
    logic        fpu_start_d, fpu_abort_d, fpu_start_q, fpu_abort_q;
`endif

    assign accept = issue_valid && (state_q == ST_IDLE);
    assign busy   = (state_q == ST_MDU_BUSY) || (state_q == ST_FPU_BUSY);

    exec_watchdog u_watchdog (
        .clk     (clk),
        .rst     (rst),
        .clear   (!busy),
        .enable  (busy),
        .limit   (8'(TIMEOUT)),
        .expired (wd_expired)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // FSM next state; flush beats done beats watchdog in the busy states.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (issue_mul_en && !issue_fpu_en)
                        state_d = ST_MDU_BUSY;
`ifdef EXEC_SCHED_FPU_EN
                    else if (issue_fpu_en && !issue_mul_en)
                        state_d = ST_FPU_BUSY;
`endif
                end
            end
            ST_MDU_BUSY: begin
                if (flush)           state_d = ST_IDLE;
                else if (mdu_done)   state_d = ST_WB;
                else if (wd_expired) state_d = ST_IDLE;
            end
            ST_FPU_BUSY: begin
`ifdef EXEC_SCHED_FPU_EN
                if (flush)           state_d = ST_IDLE;
                else if (fpu_done)   state_d = ST_WB;
                else if (wd_expired) state_d = ST_IDLE;
`else
                state_d = ST_IDLE;
`endif
            end
            ST_WB:   state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: compute the next value of every registered output.
    always_comb begin
        mdu_start_d = 1'b0;
        mdu_abort_d = 1'b0;
        illegal_d   = 1'b0;
        timeout_d   = 1'b0;
        wb_valid_d  = 1'b0;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        wb_fp_d     = wb_fp_q;
`ifdef EXEC_SCHED_FPU_EN
        fpu_start_d = 1'b0;
        fpu_abort_d = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (!issue_mul_en && !issue_fpu_en) begin
                        // ALU result retires next cycle; a same-cycle flush kills it.
                        if (issue_reg_write && !flush) begin
                            wb_valid_d = 1'b1;
                            wb_rd_d    = issue_rd;
                            wb_data_d  = alu_result;
                            wb_fp_d    = 1'b0;
                        end
                    end else if (issue_mul_en && !issue_fpu_en) begin
                        mdu_start_d = 1'b1;
                    end
`ifdef EXEC_SCHED_FPU_EN
                    else if (issue_fpu_en && !issue_mul_en) begin
                        fpu_start_d = 1'b1;
                    end
`endif
                    else begin
                        illegal_d = 1'b1;
                    end
                end
            end
            ST_MDU_BUSY: begin
                if (flush) begin
                    mdu_abort_d = 1'b1;
                end else if (mdu_done) begin
                    wb_valid_d = inst_q.reg_write;
                    wb_rd_d    = inst_q.rd;
                    wb_data_d  = mdu_result;
                    wb_fp_d    = 1'b0;
                end else if (wd_expired) begin
                    mdu_abort_d = 1'b1;
                    timeout_d   = 1'b1;
                end
            end
`ifdef EXEC_SCHED_FPU_EN
            ST_FPU_BUSY: begin
                if (flush) begin
                    fpu_abort_d = 1'b1;
                end else if (fpu_done) begin
                    wb_valid_d = inst_q.reg_write;
                    wb_rd_d    = inst_q.rd;
                    wb_data_d  = fpu_result;
                    wb_fp_d    = 1'b1;
                end else if (wd_expired) begin
                    fpu_abort_d = 1'b1;
                    timeout_d   = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    // Output and latched-instruction registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_q      <= '0;
            mdu_start_q <= 1'b0;
            mdu_abort_q <= 1'b0;
            illegal_q   <= 1'b0;
            timeout_q   <= 1'b0;
            wb_valid_q  <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_data_q   <= 32'd0;
            wb_fp_q     <= 1'b0;
        end else begin
            if (accept)
                inst_q <= '{reg_write: issue_reg_write, rd: issue_rd, op: issue_op};
            mdu_start_q <= mdu_start_d;
            mdu_abort_q <= mdu_abort_d;
            illegal_q   <= illegal_d;
            timeout_q   <= timeout_d;
            wb_valid_q  <= wb_valid_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            wb_fp_q     <= wb_fp_d;
        end
    end

`ifdef EXEC_SCHED_FPU_EN
    // FPU handshake pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            fpu_start_q <= 1'b0;
            fpu_abort_q <= 1'b0;
        end else begin
            fpu_start_q <= fpu_start_d;
            fpu_abort_q <= fpu_abort_d;
        end
    end
    assign fpu_start = fpu_start_q;
    assign fpu_abort = fpu_abort_q;
`else
    assign fpu_start = 1'b0;
    assign fpu_abort = 1'b0;
`endif

    assign issue_ready = (state_q == ST_IDLE);
    assign stall       = !issue_ready;
    assign mdu_start   = mdu_start_q;
    assign mdu_abort   = mdu_abort_q;
    assign mdu_op      = inst_q.op[OP_W_MDU-1:0];
    assign fpu_op      = inst_q.op;
    assign illegal     = illegal_q;
    assign timeout     = timeout_q;
    assign wb_valid    = wb_valid_q;
    assign wb_rd       = wb_rd_q;
    assign wb_data     = wb_data_q;
    assign wb_fp       = wb_fp_q;

endmodule

// File: doc/exec_scheduler.md
# exec_scheduler

Sequences the execute stage of the RV32IMF core between the single-cycle ALU and the multi-cycle MDU (mul/div) and FPU.
- Accepts one decoded instruction at a time, using the decoder's `mul_en`/`fpu_en` steering.
- Launches the selected multi-cycle unit and stalls the front end until it returns.
- Owns the single writeback port shared by all three result sources.
- Aborts a hung or flushed unit.

## Interface
Parameters:
- `TIMEOUT`, default 64: max cycles from unit start to `done` before watchdog abort; range 2–255.

Ports:
- `clk` in 1: clock; all state changes on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `issue_valid` in 1: decoded instruction present.
- `issue_ready` out 1: scheduler can accept; an issue is accepted when `issue_valid && issue_ready`.
- `issue_mul_en` in 1: route to MDU.
- `issue_fpu_en` in 1: route to FPU.
- `issue_reg_write` in 1: instruction writes `rd`.
- `issue_rd` in 5: destination register.
- `issue_op` in 5: unit opcode; MDU uses `[2:0]` (funct3), FPU uses all 5 (funct7[6:2]).
- `alu_result` in 32: ALU result, valid in the accept cycle.
- `flush` in 1: kill the in-flight instruction.
- `mdu_start` out 1: one-cycle launch pulse.
- `mdu_op` out 3: opcode to the MDU.
- `mdu_abort` out 1: one-cycle abort pulse.
- `mdu_done` in 1: MDU result valid.
- `mdu_result` in 32: MDU result.
- `fpu_start` out 1: one-cycle launch pulse.
- `fpu_op` out 5: opcode to the FPU.
- `fpu_abort` out 1: one-cycle abort pulse.
- `fpu_done` in 1: FPU result valid.
- `fpu_result` in 32: FPU result.
- `stall` out 1: equals `!issue_ready`.
- `wb_valid` out 1: writeback strobe.
- `wb_rd` out 5: writeback destination.
- `wb_data` out 32: writeback data.
- `wb_fp` out 1: destination is the FP register file.
- `illegal` out 1: one-cycle pulse for an unsupported instruction.
- `timeout` out 1: one-cycle pulse when the watchdog fires.

## Operation
- **FSM states:** IDLE, MDU_BUSY, FPU_BUSY, WB. Reset → IDLE.
- **IDLE:** `issue_ready=1`. On accept:
  - Neither enable set (ALU): register `alu_result`/`rd`. If `issue_reg_write`, `wb_valid=1` next cycle. Stay IDLE, so back-to-back ALU ops are allowed.
  - `mul_en` only: latch `rd`, `reg_write` and `op`; → MDU_BUSY.
  - `fpu_en` only: latch the same; `wb_fp=1` for the later writeback; → FPU_BUSY.
  - Both enables set: `illegal` pulse next cycle, no writeback, stay IDLE.
- **MDU_BUSY / FPU_BUSY:**
  - `*_start` is high only in the first cycle of the state; `*_op` is held stable for the whole state.
  - Watchdog counter clears to 0 on entry and increments each cycle.
  - On `*_done`: capture the result and → WB. A `*_done` arriving in the same cycle as `*_start` is legal.
  - On `flush`: pulse `*_abort` and → IDLE, no writeback.
  - When counter reaches `TIMEOUT-1` without `done`: pulse `*_abort` and `timeout`, → IDLE, no writeback.
  - Priority: `flush` > `done` > timeout.
- **WB:** `wb_valid=issue_reg_write_latched`; → IDLE next cycle. `issue_ready=0` in WB.
- **`done` handling:** `done` from the idle unit, or from the other unit, is ignored.
- **`flush` in IDLE:** kills the registered ALU writeback of an instruction accepted in that same cycle.
- **Writeback of `rd=0`:** `wb_valid` follows `reg_write` unchanged; the register file discards x0.
- **Reset mid-operation:** → IDLE, no abort pulse. Units are reset by the same `rst`.
- **Outputs at reset:** all 0 except `issue_ready=1`.

## Timing
- **ALU op** accepted at T: `wb_valid` at T+1.
- **MDU/FPU op** accepted at T:
  - `*_start` at T+1.
  - `stall` high from T+1.
  - `done` at cycle D: `wb_valid` at D+1, `issue_ready` at D+2.
- **Minimum multi-cycle occupancy:** 3 cycles (done coincident with start).
- **Watchdog:** fires at T+TIMEOUT when no `done` has arrived.
- **Outputs:** `wb_*`, `*_start`, `*_abort`, `illegal` and `timeout` are registered. `issue_ready` and `stall` are decoded from FSM state only, with no combinational path from inputs.

## Configuration
- `EXEC_SCHED_FPU_EN` defined: FPU path present as above.
- Undefined:
  - FPU ports remain but `fpu_start`/`fpu_abort` are tied 0 and `fpu_done`/`fpu_result` are unused.
  - FPU_BUSY is not built.
  - An accept with `fpu_en=1` produces an `illegal` pulse at T+1 and no writeback (RV32IM build).

## Structure
- **Package `exec_sched_pkg`:** FSM state enum, `OP_W_MDU=3`, `OP_W_FPU=5`, and `TIMEOUT` default.
- **Sub-module `exec_watchdog`:** 8-bit counter with `clear`, `enable`, `limit` inputs and an `expired` output. Instantiated once and shared by both busy states.

## Test plan
- **ALU back-to-back:** three ALU issues with `alu_result` = 0x11, 0x22, 0x33 and rd = 1, 2, 3 → `wb_valid` on three consecutive cycles with matching data; `stall` stays 0.
- **MDU op:** `mul_en`, op=3'b000, rd=5, `mdu_done` 4 cycles after `mdu_start` with 0xDEADBEEF → one `mdu_start` pulse; `wb_data`=0xDEADBEEF, `wb_rd`=5, `wb_fp`=0; `issue_ready` returns 1 cycle after `wb_valid`.
- **FPU op:** `fpu_en`, op=5'b00000, rd=7, `fpu_done` in the same cycle as `fpu_start` → `wb_fp`=1 and `wb_valid` 2 cycles after accept. With macro undefined: `illegal` pulse, no `wb_valid`.
- **Timeout:** TIMEOUT=8, MDU never asserts `done` → `mdu_abort` and `timeout` pulse exactly 8 cycles after accept; then IDLE with no writeback.
- **Flush and done coincident:** `flush` and `mdu_done` in the same cycle → `mdu_abort` pulses, no `wb_valid`. A stray `fpu_done` during MDU_BUSY is ignored.
